// File: rtl/motor_speed_ctrl_if.sv
// Interface between the host/motor side and motor_speed_ctrl.
//   motor_enable  run request (level)
//   zero_flag     one-cycle pulse per revolution
//   duty          PWM duty command
//   motor_speed   last measured (or averaged) revolution period, clk cycles
//   speed_locked  speed held in band for the required number of revolutions
//   stall_fault   sticky stall indication
//   ctrl_state    encoded controller state
// Modport slave is the controller side, master is the driving side.
interface motor_speed_ctrl_if #(
   parameter int PERIOD_W = 32,
   parameter int DUTY_W   = 10
);
   logic                motor_enable;
   logic                zero_flag;
   logic [DUTY_W-1:0]   duty;
   logic [PERIOD_W-1:0] motor_speed;
   logic                speed_locked;
   logic                stall_fault;
   logic [2:0]          ctrl_state;

   modport slave (
      input  motor_enable, zero_flag,
      output duty, motor_speed, speed_locked, stall_fault, ctrl_state
   );

   modport master (
      output motor_enable, zero_flag,
      input  duty, motor_speed, speed_locked, stall_fault, ctrl_state
   );
endinterface

// File: rtl/motor_speed_ctrl.sv
// Closed-loop spin-up and speed regulator for the scanner motor.
// Measures the clk-cycle period between zero pulses, steps the PWM duty
// towards TARGET_PERIOD, and reports lock and stall status.
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  motor_speed_ctrl_if.slave (motor_enable, zero_flag in;
//        duty, motor_speed, speed_locked, stall_fault, ctrl_state out)
//
// Optional build macro SPEED_FILTER_EN: regulation and lock act on a 4-tap
// moving average of the period (one extra cycle of latency) and motor_speed
// reports that average. Without it the raw period is used.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE   0  | motor off, duty 0, period counter held at 0
// SPINUP 1  | duty = DUTY_START, first pulse arms, second latches period
// REGULATE 2| duty stepped once per revolution towards the target band
// LOCKED 3  | as REGULATE, speed in band for LOCK_REVS revolutions
// FAULT  4  | stall timeout hit, duty 0, held until motor_enable drops
module motor_speed_ctrl #(
   parameter int PERIOD_W      = 32,
   parameter int DUTY_W        = 10,
   parameter int TARGET_PERIOD = 2500000,
   parameter int LOCK_TOL      = 2500,
   parameter int LOCK_REVS     = 4,
   parameter int STALL_TIMEOUT = 10000000,
   parameter int DUTY_START    = 600,
   parameter int DUTY_MIN      = 100,
   parameter int DUTY_STEP     = 1
) (
   input  logic              clk,
   input  logic              rst,
   motor_speed_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SPINUP   = 3'd1,
      S_REGULATE = 3'd2,
      S_LOCKED   = 3'd3,
      S_FAULT    = 3'd4
   } state_t;

   localparam int CMP_W  = PERIOD_W + 2;
   localparam int GOOD_W = $clog2(LOCK_REVS + 1);

   localparam logic [CMP_W-1:0]    BAND_HI      = CMP_W'(TARGET_PERIOD + LOCK_TOL);
   localparam logic [CMP_W-1:0]    BAND_LO      = CMP_W'(TARGET_PERIOD - LOCK_TOL);
   localparam logic [PERIOD_W-1:0] STALL_CNT    = PERIOD_W'(STALL_TIMEOUT);
   localparam logic [DUTY_W:0]     DUTY_MAX_X   = {1'b0, {DUTY_W{1'b1}}};
   localparam logic [DUTY_W:0]     DUTY_MIN_X   = (DUTY_W+1)'(DUTY_MIN);
   localparam logic [DUTY_W:0]     DUTY_STEP_X  = (DUTY_W+1)'(DUTY_STEP);
   localparam logic [DUTY_W-1:0]   DUTY_START_V = DUTY_W'(DUTY_START);

   state_t              state_q, state_d;
   logic [PERIOD_W-1:0] cnt_q;
   logic                armed_q, armed_d;
   logic [GOOD_W-1:0]   good_q, good_d;
   logic [DUTY_W-1:0]   duty_q, duty_d;
   logic                locked_q, locked_d;
   logic                fault_q, fault_d;
   logic [PERIOD_W-1:0] speed_q, speed_d;

   logic [PERIOD_W-1:0] period_p;
   logic                in_reg;
   logic                stall_hit;
   logic                meas_valid;
   logic [PERIOD_W-1:0] meas_p;
   logic [CMP_W-1:0]    meas_x;
   logic                too_slow, too_fast;
   logic [DUTY_W:0]     duty_x, duty_sum;
   logic [DUTY_W-1:0]   duty_up, duty_dn;
   logic                lock_reached;

   assign period_p  = cnt_q + PERIOD_W'(1);
   assign in_reg    = (state_q == S_REGULATE) || (state_q == S_LOCKED);
   // A pulse in the same cycle as the timeout takes priority over the fault.
   assign stall_hit = (cnt_q == STALL_CNT) && !bus.zero_flag;

`ifdef SPEED_FILTER_EN
   logic [PERIOD_W-1:0] win_q [4];
   logic                eval_q;
   logic [CMP_W-1:0]    win_sum;

   assign win_sum    = CMP_W'(win_q[0]) + CMP_W'(win_q[1]) +
                       CMP_W'(win_q[2]) + CMP_W'(win_q[3]);
   // Decision is taken the cycle after the pulse, once the window holds it.
   assign meas_valid = eval_q && in_reg;
   assign meas_p     = PERIOD_W'(win_sum >> 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) win_q[i] <= '0;
         eval_q <= 1'b0;
      end else begin
         eval_q <= bus.zero_flag && in_reg;
         if (bus.zero_flag && (state_q == S_SPINUP) && armed_q) begin
            for (int i = 0; i < 4; i++) win_q[i] <= period_p;
         end else if (bus.zero_flag && in_reg) begin
            win_q[0] <= period_p;
            win_q[1] <= win_q[0];
            win_q[2] <= win_q[1];
            win_q[3] <= win_q[2];
         end
      end
   end
`else
   assign meas_valid = bus.zero_flag && in_reg;
   assign meas_p     = period_p;
`endif

   assign meas_x   = CMP_W'(meas_p);
   assign too_slow = meas_x > BAND_HI;
   assign too_fast = meas_x < BAND_LO;

   assign duty_x   = {1'b0, duty_q};
   assign duty_sum = duty_x + DUTY_STEP_X;
   assign duty_up  = (duty_sum > DUTY_MAX_X) ? {DUTY_W{1'b1}} : duty_sum[DUTY_W-1:0];
   assign duty_dn  = (duty_x < DUTY_MIN_X + DUTY_STEP_X) ? DUTY_MIN_X[DUTY_W-1:0]
                                                          : duty_q - DUTY_STEP_X[DUTY_W-1:0];

   assign lock_reached = (int'(good_q) + 1) >= LOCK_REVS;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      armed_d  = armed_q;
      good_d   = good_q;
      duty_d   = duty_q;
      locked_d = locked_q;
      fault_d  = fault_q;
      speed_d  = speed_q;

      if (!bus.motor_enable) begin
         state_d  = S_IDLE;
         armed_d  = 1'b0;
         good_d   = '0;
         duty_d   = '0;
         locked_d = 1'b0;
         fault_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_SPINUP;
               duty_d  = DUTY_START_V;
               armed_d = 1'b0;
               good_d  = '0;
            end
            S_SPINUP: begin
               if (bus.zero_flag) begin
                  if (armed_q) begin
                     state_d = S_REGULATE;
                     speed_d = period_p;
                  end else begin
                     armed_d = 1'b1;
                  end
               end
            end
            S_REGULATE, S_LOCKED: begin
               if (meas_valid) begin
                  speed_d = meas_p;
                  if (too_slow)      duty_d = duty_up;
                  else if (too_fast) duty_d = duty_dn;
                  if (too_slow || too_fast) begin
                     good_d   = '0;
                     locked_d = 1'b0;
                     state_d  = S_REGULATE;
                  end else begin
                     if (int'(good_q) < LOCK_REVS) good_d = good_q + GOOD_W'(1);
                     if ((state_q == S_REGULATE) && lock_reached) begin
                        state_d  = S_LOCKED;
                        locked_d = 1'b1;
                     end
                  end
               end
            end
            S_FAULT: begin
               duty_d   = '0;
               locked_d = 1'b0;
               fault_d  = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase

         if ((state_q == S_SPINUP || in_reg) && stall_hit) begin
            state_d  = S_FAULT;
            duty_d   = '0;
            locked_d = 1'b0;
            fault_d  = 1'b1;
            good_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         armed_q  <= 1'b0;
         good_q   <= '0;
         duty_q   <= '0;
         locked_q <= 1'b0;
         fault_q  <= 1'b0;
         speed_q  <= '0;
      end else begin
         if ((state_q == S_IDLE) || bus.zero_flag) cnt_q <= '0;
         else if (cnt_q < STALL_CNT)               cnt_q <= cnt_q + PERIOD_W'(1);
         armed_q  <= armed_d;
         good_q   <= good_d;
         duty_q   <= duty_d;
         locked_q <= locked_d;
         fault_q  <= fault_d;
         speed_q  <= speed_d;
      end
   end

   assign bus.duty         = duty_q;
   assign bus.motor_speed  = speed_q;
   assign bus.speed_locked = locked_q;
   assign bus.stall_fault  = fault_q;
   assign bus.ctrl_state   = state_q;

endmodule
